// File: rtl/mux_pkg.sv
// Shared defaults for the 4:1 selector slice.
// Holds the group width, group count and derived select width used by the mux blocks.
package mux_pkg;

   localparam int DEFAULT_DATA_W = 4;
   localparam int DEFAULT_NUM_IN = 4;

   // A single-group mux still needs a 1-bit select port.
   function automatic int sel_width(input int num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

   localparam int DEFAULT_SEL_W = sel_width(DEFAULT_NUM_IN);

endpackage

// File: rtl/mux_sel_comb.sv
// Purely combinational group selector.
// A select index past the last group drives zeros.
module mux_sel_comb
   import mux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NUM_IN = DEFAULT_NUM_IN,
   parameter int SEL_W  = sel_width(NUM_IN)
) (
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   output logic [DATA_W-1:0]        out_data
);

   logic [31:0]       sel_idx_s;
   logic [DATA_W-1:0] out_s;

   // Pick group sel, or zeros when sel names a group that does not exist.
   always_comb begin
      sel_idx_s = 32'(sel);
      out_s     = {DATA_W{1'b0}};
      if (sel_idx_s < 32'(NUM_IN)) begin
         out_s = in_data[sel_idx_s*DATA_W +: DATA_W];
      end else begin
         out_s = {DATA_W{1'b0}};
      end
   end

   assign out_data = out_s;

endmodule

// File: rtl/module_mux_41.sv
// 4:1 mux with combinational output plus an enabled capture register.
// The capture register also records the select value and a valid flag.
module module_mux_41
   import mux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NUM_IN = DEFAULT_NUM_IN,
   parameter int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic                     en,
   output logic [DATA_W-1:0]        out_data,
   output logic [DATA_W-1:0]        out_data_q,
   output logic [SEL_W-1:0]         sel_q,
   output logic                     out_valid
);

   logic [DATA_W-1:0] mux_out_s;
   logic [DATA_W-1:0] data_q_r;
   logic [SEL_W-1:0]  sel_q_r;
   logic              valid_r;

   mux_sel_comb #(
      .DATA_W (DATA_W),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_sel (
      .sel      (sel),
      .in_data  (in_data),
      .out_data (mux_out_s)
   );

   // Capture register: reset wins over enable, otherwise hold when en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q_r <= {DATA_W{1'b0}};
         sel_q_r  <= {SEL_W{1'b0}};
         valid_r  <= 1'b0;
      end else if (en) begin
         data_q_r <= mux_out_s;
         sel_q_r  <= sel;
         valid_r  <= 1'b1;
      end else begin
         data_q_r <= data_q_r;
         sel_q_r  <= sel_q_r;
         valid_r  <= valid_r;
      end
   end

   assign out_data   = mux_out_s;
   assign out_data_q = data_q_r;
   assign sel_q      = sel_q_r;
   assign out_valid  = valid_r;

endmodule

// File: tb/tb_module_mux_41.sv
// Self-checking bench for module_mux_41: vector table, directed register
// sequences, and randomized traffic against a behavioural model.
module tb_module_mux_41;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  sel;
   logic [15:0] in_data;
   logic [3:0]  out_data;
   logic [3:0]  out_data_q;
   logic [1:0]  sel_q;
   logic        out_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // model of the registered outputs
   logic [3:0] m_q;
   logic [1:0] m_sel;
   logic       m_valid;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] din;
      logic [3:0]  exp;
   } vec_t;

   vec_t vecs[4];

   module_mux_41 dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .in_data    (in_data),
      .en         (en),
      .out_data   (out_data),
      .out_data_q (out_data_q),
      .sel_q      (sel_q),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: nibble number s of d, by shifting and masking
   function automatic logic [3:0] ref_mux(input logic [1:0] s, input logic [15:0] d);
      logic [15:0] shifted;
      shifted = d >> (4 * int'(s));
      return shifted[3:0];
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // one rising edge; the model samples the same inputs the DUT sees
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_q = 4'h0; m_sel = 2'b00; m_valid = 1'b0;
      end else if (en) begin
         m_q = ref_mux(sel, in_data); m_sel = sel; m_valid = 1'b1;
      end
      #1;
   endtask

   task automatic check_regs(input string name);
      check({name, "_q"},     16'(out_data_q), 16'(m_q));
      check({name, "_sel"},   16'(sel_q),      16'(m_sel));
      check({name, "_valid"}, 16'(out_valid),  16'(m_valid));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sel = 2'b00; in_data = 16'h0000;
      m_q = 4'h0; m_sel = 2'b00; m_valid = 1'b0;

      vecs[0] = '{sel: 2'b00, din: 16'hF531, exp: 4'b0001};
      vecs[1] = '{sel: 2'b01, din: 16'hF531, exp: 4'b0011};
      vecs[2] = '{sel: 2'b10, din: 16'hF531, exp: 4'b0101};
      vecs[3] = '{sel: 2'b11, din: 16'hF531, exp: 4'b1111};

      // sel sweep on a fixed word, 10 ns per step
      for (int i = 0; i < 4; i++) begin
         sel = vecs[i].sel; in_data = vecs[i].din;
         #1;
         check($sformatf("sweep%0d", i), 16'(out_data), 16'(vecs[i].exp));
         #9;
      end
      $display("sel=%b out_data=%b", sel, out_data);

      // reset for two edges, then release with en low
      rst = 1'b1; en = 1'b0;
      tick(); tick();
      check_regs("rst");
      rst = 1'b0;
      tick(); tick();
      check_regs("rst_hold");
      check("rst_hold_q_const", 16'(out_data_q), 16'h0000);
      sel = 2'b01; #1;
      check("rst_track", 16'(out_data), 16'h0003);

      // single enabled capture
      in_data = 16'hF531; sel = 2'b10; en = 1'b1;
      tick();
      en = 1'b0;
      check_regs("cap");
      check("cap_q_const", 16'(out_data_q), 16'h0005);
      check("cap_sel_const", 16'(sel_q), 16'h0002);

      // inputs change with en low: only the combinational output moves
      sel = 2'b11; in_data = 16'h0000; #1;
      check("hold_comb", 16'(out_data), 16'h0000);
      check("hold_q_pre", 16'(out_data_q), 16'h0005);
      tick();
      check_regs("hold");
      check("hold_sel_const", 16'(sel_q), 16'h0002);

      // reset and enable on the same edge; comb path keeps tracking under reset
      rst = 1'b1; en = 1'b1; sel = 2'b01; in_data = 16'hF531; #1;
      check("rst_comb", 16'(out_data), 16'h0003);
      tick();
      check_regs("rst_en");
      check("rst_en_valid_const", 16'(out_valid), 16'h0000);
      rst = 1'b0; en = 1'b0;

      // randomized traffic
      for (int i = 0; i < 1000; i++) begin
         sel     = 2'($urandom_range(0, 3));
         in_data = 16'($urandom);
         en      = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 49) == 0);
         #1;
         check("rand_comb", 16'(out_data), 16'(ref_mux(sel, in_data)));
         tick();
         check_regs("rand");
         // disturb inputs between edges; registered outputs must not follow
         in_data = 16'($urandom);
         sel     = 2'($urandom_range(0, 3));
         #1;
         check("rand_mid_q", 16'(out_data_q), 16'(m_q));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
